// File: rtl/stream_mux_rr.sv
// N_CH-input round-robin stream mux; optional packet lock via STREAM_MUX_PKT_LOCK_EN.
// Latency 1 cycle input->output; in_ready only when output register can load (~out_valid | out_ready).
module stream_mux_rr #(
  parameter int N_CH = 4,
  parameter int W    = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [CH_W-1:0]   out_chan,
  output logic              out_last
);

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] win;
  logic [CH_W-1:0] nxt_ptr;
  logic [N_CH-1:0] grant;
  logic [W-1:0]    sel_data;
  logic            sel_last;
  logic            found;
  logic            can_load;
  logic            xfer;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic            lock;
`endif

  // While locked, rr_ptr holds the channel whose packet is in flight.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock) begin
      found = in_valid[rr_ptr];
      win   = rr_ptr;
    end else
`endif
    begin
      for (int k = 0; k < N_CH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          win   = CH_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[win] = 1'b1;
  end

  assign can_load = ~out_valid | out_ready;
  assign in_ready = can_load ? grant : '0;
  assign xfer     = found & can_load;
  assign nxt_ptr  = (int'(win) == N_CH - 1) ? '0 : win + 1'b1;
  assign sel_data = in_data[int'(win)*W +: W];
  assign sel_last = in_last[win];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      rr_ptr    <= '0;
    end else if (can_load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_chan <= win;
        out_last <= sel_last;
`ifdef STREAM_MUX_PKT_LOCK_EN
        rr_ptr   <= sel_last ? nxt_ptr : win;
`else
        rr_ptr   <= nxt_ptr;
`endif
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lock <= 1'b0;
    else if (xfer) lock <= ~sel_last;
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N_CH=4, W=4); expectations hand-computed per scenario.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_last;

  int passed = 0;
  int total  = 0;

  stream_mux_rr #(.N_CH(4), .W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
    rst_n = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_data !== 4'h0) $display("FAIL rst_data got %h exp 0", out_data); else passed++;
    total++; if (out_chan !== 2'd0) $display("FAIL rst_chan got %0d exp 0", out_chan); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL rst_last got %b exp 0", out_last); else passed++;
    total++; if (in_ready !== 4'b0000) $display("FAIL rst_ready got %b exp 0000", in_ready); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 4'b0001; in_data = 16'h000a;
    #1;
    total++; if (in_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", in_ready); else passed++;
    step();
    in_valid = 4'b0000;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_data !== 4'ha) $display("FAIL single_data got %h exp a", out_data); else passed++;
    total++; if (out_chan !== 2'd0) $display("FAIL single_chan got %0d exp 0", out_chan); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL idle_drain got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_chan [5];
    logic [3:0] exp_data [5];
    exp_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_data = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
    do_reset();
    in_valid = 4'b1111; in_data = 16'hdcba;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_chan !== exp_chan[i])
        $display("FAIL rr_chan[%0d] got v=%b ch=%0d exp v=1 ch=%0d", i, out_valid, out_chan, exp_chan[i]);
      else passed++;
      total++; if (out_data !== exp_data[i]) $display("FAIL rr_data[%0d] got %h exp %h", i, out_data, exp_data[i]);
      else passed++;
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure_wrap();
    do_reset();
    in_valid = 4'b1111; in_data = 16'hdcba;
    step(); step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b exp 0000", i, in_ready); else passed++;
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 4'hc || out_chan !== 2'd2)
        $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d exp v=1 d=c ch=2", i, out_valid, out_data, out_chan);
      else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b1000) $display("FAIL bp_release_ready got %b exp 1000", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 4'hd || out_chan !== 2'd3)
      $display("FAIL bp_release got v=%b d=%h ch=%0d exp v=1 d=d ch=3", out_valid, out_data, out_chan);
    else passed++;
    // rr_ptr has wrapped to 0; ch3 alone must still win immediately.
    in_valid = 4'b1000;
    #1;
    total++; if (in_ready !== 4'b1000) $display("FAIL wrap_ready got %b exp 1000", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_chan !== 2'd3)
      $display("FAIL wrap_chan got v=%b ch=%0d exp v=1 ch=3", out_valid, out_chan);
    else passed++;
    in_valid = '0;
  endtask

  task automatic test_packet();
    logic [1:0] exp_chan [4];
    logic [3:0] exp_data [4];
    logic       exp_last [4];
    int ch1_idx;
    logic ch2_done;
    logic [3:0] acc;
`ifdef STREAM_MUX_PKT_LOCK_EN
    exp_chan = '{2'd1, 2'd1, 2'd1, 2'd2};
    exp_data = '{4'h1, 4'h2, 4'h3, 4'he};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_chan = '{2'd1, 2'd2, 2'd1, 2'd1};
    exp_data = '{4'h1, 4'he, 4'h2, 4'h3};
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    ch1_idx = 0;
    ch2_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = {1'b0, ~ch2_done, (ch1_idx < 3), 1'b0};
      in_data  = {4'h0, 4'he, 4'(ch1_idx + 1), 4'h0};
      in_last  = {1'b0, 1'b1, (ch1_idx == 2), 1'b0};
      #1;
      acc = in_ready & in_valid;
      step();
      if (acc[1]) ch1_idx++;
      if (acc[2]) ch2_done = 1'b1;
      total++; if (out_valid !== 1'b1 || out_chan !== exp_chan[i] || out_data !== exp_data[i] || out_last !== exp_last[i])
        $display("FAIL pkt[%0d] got v=%b ch=%0d d=%h l=%b exp v=1 ch=%0d d=%h l=%b",
                 i, out_valid, out_chan, out_data, out_last, exp_chan[i], exp_data[i], exp_last[i]);
      else passed++;
    end
    in_valid = '0; in_last = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid = 4'b1111; in_data = 16'hdcba;
    step(); step();
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_chan !== 2'd0)
      $display("FAIL async_rst got v=%b ch=%0d exp v=0 ch=0", out_valid, out_chan);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) $display("FAIL rst_restart_ready got %b exp 0001", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 4'ha)
      $display("FAIL rst_restart got v=%b ch=%0d d=%h exp v=1 ch=0 d=a", out_valid, out_chan, out_data);
    else passed++;
    in_valid = '0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure_wrap();
    test_packet();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
